// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access/writeback stage.
package mem_stage_pkg;

  localparam int XLEN = 64;

  localparam logic [7:0] WSTRB_DW = 8'hFF;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage.sv
// RV64 memory-access/writeback stage: passes ALU results through, runs LD/SD
// over a valid/ready request channel and emits one registered writeback record.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int RSP_TIMEOUT = 255,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic            mem_we,
  input  logic            mem_to_reg,
  input  logic            rd_we,
  input  logic [4:0]      rd_addr,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            err_misaligned,
  output logic            err_timeout
);

  localparam logic [8:0] TMO_LIMIT = 9'(RSP_TIMEOUT);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            rd_we_q, rd_we_d;
  logic [4:0]      rd_q, rd_d;

  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            err_mis_q, err_mis_d;
  logic            err_to_q, err_to_d;

  logic accept, is_mem, misaligned;

  assign accept     = ex_valid && (state_q == ST_IDLE);
  assign is_mem     = mem_we || mem_to_reg;
  assign misaligned = ALIGN_CHECK && (alu_result[2:0] != 3'b000);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rd_we_d    = rd_we_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = rd_we;
            wb_rd_d    = rd_addr;
            wb_data_d  = alu_result;
          end else begin
            addr_d  = alu_result;
            wdata_d = store_data;
            we_d    = mem_we;
            rd_we_d = rd_we;
            rd_d    = rd_addr;
            // Misaligned access never reaches memory; retire it as a flagged no-op.
            if (misaligned) begin
              wb_valid_d = 1'b1;
              err_mis_d  = 1'b1;
              wb_rd_d    = rd_addr;
              wb_data_d  = '0;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Response wins over a timeout landing in the same cycle.
        if (dmem_rsp_valid) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_we_d    = !we_q && rd_we_q;
          wb_rd_d    = rd_q;
          wb_data_d  = we_q ? '0 : dmem_rsp_rdata;
        end else if (({1'b0, cnt_q} + 9'd1) == TMO_LIMIT) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          err_to_d   = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rd_we_q    <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rd_we_q    <= rd_we_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
    end
  end

  assign ex_ready       = (state_q == ST_IDLE);
  assign dmem_req_valid = (state_q == ST_REQ);
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_we        = dmem_req_valid && we_q;
  assign dmem_wstrb     = (dmem_req_valid && we_q) ? WSTRB_DW : 8'h00;

  assign wb_valid       = wb_valid_q;
  assign wb_we          = wb_we_q;
  assign wb_rd_addr     = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule
